// File: rtl/shared_alu_server.sv
`default_nettype none
// ============================================================================
//  Module      : shared_alu_server
//  Description : Two-client round-robin ALU server. A request is granted,
//                executed and answered in three states: IDLE, EXEC and RESP.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_alu_server #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req0_i,
    input  logic [2:0]       op0_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic             req1_i,
    input  logic [2:0]       op1_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             valid0_o,
    output logic             valid1_o,
    output logic [WIDTH-1:0] res_o,
    output logic             busy_o
);

    localparam int         c_SHAMT_W = $clog2(WIDTH);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_EXEC    = 2'd1;
    localparam logic [1:0] c_RESP    = 2'd2;

    logic [1:0]       r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_valid0;
    logic             r_valid1;

    logic             w_req0;
    logic             w_req1;
    logic             w_win;
    logic [WIDTH-1:0] w_alu;

    // A client still holding req during its own valid cycle is not re-granted.
    assign w_req0 = req0_i & ~r_valid0;
    assign w_req1 = req1_i & ~r_valid1;
    assign w_win  = (w_req0 && w_req1) ? r_ptr : w_req1;

    always_comb begin
        w_alu = '0;
        case (r_op)
            3'b000:  w_alu = r_a + r_b;
            3'b001:  w_alu = r_a << r_b[c_SHAMT_W-1:0];
            3'b010:  w_alu = r_a >> r_b[c_SHAMT_W-1:0];
            3'b011:  w_alu = r_a & r_b;
            3'b100:  w_alu = r_a - r_b;
            3'b101:  w_alu = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            3'b110:  w_alu = r_a ^ r_b;
            default: w_alu = r_a | r_b;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= c_IDLE;
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_req0 || w_req1) begin
                        r_owner <= w_win;
                        r_ptr   <= ~w_win;
                        r_op    <= w_win ? op1_i : op0_i;
                        r_a     <= w_win ? a1_i  : a0_i;
                        r_b     <= w_win ? b1_i  : b0_i;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    r_res   <= w_alu;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_valid0 <= ~r_owner;
                    r_valid1 <= r_owner;
                    r_state  <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign gnt0_o   = r_gnt0;
    assign gnt1_o   = r_gnt1;
    assign valid0_o = r_valid0;
    assign valid1_o = r_valid1;
    assign res_o    = r_res;
    assign busy_o   = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shared_alu_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_alu_server
//  Description : Self-checking bench for shared_alu_server (vector table,
//                per-client result scoreboards, handwritten corner sequences).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_alu_server;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, valid0, valid1, busy;
    logic [31:0] res;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    typedef struct {
        logic        c;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    shared_alu_server #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req0_i  (req0),
        .op0_i   (op0),
        .a0_i    (a0),
        .b0_i    (b0),
        .req1_i  (req1),
        .op1_i   (op1),
        .a1_i    (a1),
        .b1_i    (b1),
        .gnt0_o  (gnt0),
        .gnt1_o  (gnt1),
        .valid0_o(valid0),
        .valid1_o(valid1),
        .res_o   (res),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: results are compared whenever a valid pulse appears.
    always begin
        @(posedge clk);
        #1;
        if (gnt0 && gnt1) begin
            n_tests++; n_fail++;
            $display("FAIL gnt_exclusive: both gnt high at %0t", $time);
        end
        if (valid0 && valid1) begin
            n_tests++; n_fail++;
            $display("FAIL valid_exclusive: both valid high at %0t", $time);
        end
        if (valid0) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL valid0_unexpected: got valid0 with res %h, expected no pulse", res);
            end else check("res_client0", res, q0.pop_front());
        end
        if (valid1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL valid1_unexpected: got valid1 with res %h, expected no pulse", res);
            end else check("res_client1", res, q1.pop_front());
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_gnt", {30'b0, gnt1, gnt0}, 32'd0);
        check("rst_valid", {30'b0, valid1, valid0}, 32'd0);
        rst_ni = 1'b1;
    endtask

    task automatic do_txn(input logic c, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        logic got;
        if (c) begin
            q1.push_back(exp);
            op1 = op; a1 = a; b1 = b; req1 = 1'b1;
        end else begin
            q0.push_back(exp);
            op0 = op; a0 = a; b0 = b; req0 = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (c ? gnt1 : gnt0) got = 1'b1;
        end
        check("gnt_seen", {31'b0, got}, 32'd1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (c ? valid1 : valid0) got = 1'b1;
        end
        check("valid_seen", {31'b0, got}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        logic [1:0] who;

        vecs[0]  = '{1'b1, 3'b001, 32'h1,        32'd31,       32'h8000_0000};
        vecs[1]  = '{1'b1, 3'b010, 32'h8000_0000, 32'd31,      32'h1};
        vecs[2]  = '{1'b1, 3'b101, 32'd3,        32'd5,        32'd1};
        vecs[3]  = '{1'b1, 3'b101, 32'd5,        32'd3,        32'd0};
        vecs[4]  = '{1'b1, 3'b110, 32'hFF,       32'h0F,       32'hF0};
        vecs[5]  = '{1'b1, 3'b111, 32'hF0,       32'h0F,       32'hFF};
        vecs[6]  = '{1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1,       32'h0};
        vecs[7]  = '{1'b0, 3'b011, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'hDEAD_0000};
        vecs[8]  = '{1'b0, 3'b100, 32'd10,       32'd3,        32'd7};
        vecs[9]  = '{1'b0, 3'b001, 32'h3,        32'h24,       32'h30};
        vecs[10] = '{1'b0, 3'b101, 32'h8000_0000, 32'h1,       32'd0};
        vecs[11] = '{1'b0, 3'b010, 32'hF000_0000, 32'h0000_0104, 32'h0F00_0000};

        do_reset();

        // Single client 0 ADD with exact cycle timing; rst released with req.
        op0 = 3'b000; a0 = 32'd5; b0 = 32'd7; req0 = 1'b1;
        q0.push_back(32'd12);
        tick();
        check("t28_gnt0_N", {31'b0, gnt0}, 32'd1);
        check("t28_gnt1_N", {31'b0, gnt1}, 32'd0);
        check("t28_busy_N", {31'b0, busy}, 32'd1);
        tick();
        check("t28_res_N1", res, 32'd12);
        check("t28_gnt0_N1", {31'b0, gnt0}, 32'd0);
        check("t28_busy_N1", {31'b0, busy}, 32'd1);
        tick();
        check("t28_valid0_N2", {31'b0, valid0}, 32'd1);
        check("t28_busy_N2", {31'b0, busy}, 32'd0);
        req0 = 1'b0;
        tick();
        check("t28_no_regrant", {31'b0, gnt0}, 32'd0);
        check("t28_valid_pulse", {31'b0, valid0}, 32'd0);

        // Tie after reset: client 0 first; it keeps req during its valid cycle.
        do_reset();
        op0 = 3'b100; a0 = 32'd0;  b0 = 32'd1;  req0 = 1'b1;
        op1 = 3'b011; a1 = 32'hF0; b1 = 32'h3C; req1 = 1'b1;
        q0.push_back(32'hFFFF_FFFF);
        q1.push_back(32'h30);
        tick();
        check("t29_gnt0_first", {30'b0, gnt1, gnt0}, 32'd1);
        tick();
        tick();
        check("t29_valid0", {31'b0, valid0}, 32'd1);
        tick();
        check("t29_gnt1_next", {30'b0, gnt1, gnt0}, 32'd2);
        req0 = 1'b0;
        tick();
        tick();
        check("t29_valid1", {31'b0, valid1}, 32'd1);
        req1 = 1'b0;
        tick();

        // Both clients requesting continuously: grants alternate.
        do_reset();
        op0 = 3'b000; a0 = 32'd1; b0 = 32'd2; req0 = 1'b1;
        op1 = 3'b110; a1 = 32'd6; b1 = 32'd3; req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            who = 2'b00;
            for (int k = 0; k < 10 && !got; k++) begin
                tick();
                if (gnt0 || gnt1) begin
                    got = 1'b1;
                    who = {gnt1, gnt0};
                end
            end
            check($sformatf("t30_grant%0d", g), {30'b0, who}, (g % 2 == 0) ? 32'd1 : 32'd2);
            if (who == 2'b01) q0.push_back(32'd3);
            if (who == 2'b10) q1.push_back(32'd5);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        // Vector table.
        for (int i = 0; i < 12; i++)
            do_txn(vecs[i].c, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        tick();

        // Reset while in EXEC aborts the transaction; res_o was non-zero before.
        op0 = 3'b000; a0 = 32'd1; b0 = 32'd1; req0 = 1'b1;
        tick();
        check("t32_gnt0", {31'b0, gnt0}, 32'd1);
        rst_ni = 1'b0;
        req0 = 1'b0;
        tick();
        check("t32_busy", {31'b0, busy}, 32'd0);
        check("t32_res", res, 32'd0);
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t32_no_valid", {30'b0, valid1, valid0}, 32'd0);
        end
        do_txn(1'b0, 3'b000, 32'd40, 32'd2, 32'd42);

        tick();
        tick();
        check("sb_q0_empty", q0.size(), 32'd0);
        check("sb_q1_empty", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
